// File: rtl/riscv_core.sv
// Single-cycle RV64I core with private instruction and data memories.
// Fetch, decode, execute, memory access and writeback are all combinational;
// the rising clock edge commits pc, one register write and one store.
module riscv_core #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned IMEM_WORDS  = 4096,
  parameter int unsigned DMEM_DWORDS = 4096,
  parameter string       IMEM_INIT   = ""
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned ImemAw = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DmemAw = (DMEM_DWORDS > 1) ? $clog2(DMEM_DWORDS) : 1;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpReg32  = 7'b0111011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

  // Architectural state; names are used as probe points by the simulation model.
  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [63:0] dmem [0:DMEM_DWORDS-1];
  logic [63:0] regs [0:31];
  logic [63:0] pc;
  logic        halted;

  logic [63:0] pc_d;
  logic        halted_d;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // ---------------------------------------------------------------------------
  // Fetch and field decode
  // ---------------------------------------------------------------------------
  logic [ImemAw-1:0] imem_idx;
  logic [31:0]       instr;
  logic [6:0]        opcode;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [63:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [63:0]       rs1_val, rs2_val, pc_plus4;

  assign imem_idx = ImemAw'((pc >> 2) % 64'(IMEM_WORDS));
  assign instr    = imem[imem_idx];
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];

  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'h000};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 64'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 64'd0 : regs[rs2];
  assign pc_plus4 = pc + 64'd4;

  // ---------------------------------------------------------------------------
  // Data memory access: the byte lane is aligned down to the access size so an
  // access never straddles a doubleword.
  // ---------------------------------------------------------------------------
  logic [63:0]       mem_addr;
  logic [DmemAw-1:0] dmem_idx;
  logic [2:0]        lane;
  logic [63:0]       dmem_rdata, ld_shifted, ld_val;
  logic              ld_valid;
  logic [7:0]        st_size_mask, st_byte_en;
  logic [63:0]       st_bit_mask, st_wdata, st_merged;

  assign mem_addr   = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
  assign dmem_idx   = DmemAw'((mem_addr >> 3) % 64'(DMEM_DWORDS));
  assign dmem_rdata = dmem[dmem_idx];
  assign ld_shifted = dmem_rdata >> {lane, 3'b000};
  assign st_wdata   = rs2_val << {lane, 3'b000};
  assign st_byte_en = st_size_mask << lane;
  assign st_merged  = (dmem_rdata & ~st_bit_mask) | (st_wdata & st_bit_mask);

  // Access size selects lane alignment and store byte mask.
  always_comb begin
    lane         = 3'd0;
    st_size_mask = 8'h00;
    case (funct3[1:0])
      2'd0: begin lane = mem_addr[2:0];               st_size_mask = 8'h01; end
      2'd1: begin lane = {mem_addr[2:1], 1'b0};       st_size_mask = 8'h03; end
      2'd2: begin lane = {mem_addr[2], 2'b00};        st_size_mask = 8'h0F; end
      default: begin lane = 3'd0;                     st_size_mask = 8'hFF; end
    endcase
  end

  // Expand the byte enables to a bit mask for the read-modify-write merge.
  always_comb begin
    st_bit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      st_bit_mask[i*8 +: 8] = {8{st_byte_en[i]}};
    end
  end

  // Load result extension.
  always_comb begin
    ld_val   = '0;
    ld_valid = 1'b1;
    case (funct3)
      3'b000:  ld_val = {{56{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_val = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b010:  ld_val = sext32(ld_shifted[31:0]);
      3'b011:  ld_val = ld_shifted;
      3'b100:  ld_val = {56'd0, ld_shifted[7:0]};
      3'b101:  ld_val = {48'd0, ld_shifted[15:0]};
      3'b110:  ld_val = {32'd0, ld_shifted[31:0]};
      default: ld_valid = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch condition
  // ---------------------------------------------------------------------------
  logic br_taken, br_valid;

  // Branch comparison; funct3 010/011 are not branches and fall through as NOP.
  always_comb begin
    br_taken = 1'b0;
    br_valid = 1'b1;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_valid = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Execute / writeback select
  // ---------------------------------------------------------------------------
  logic        rd_we;
  logic [63:0] rd_val;
  logic        st_we;

  // Next pc, register writeback and store enable; anything unrecognised is a NOP.
  always_comb begin
    pc_d     = pc_plus4;
    halted_d = halted;
    rd_we    = 1'b0;
    rd_val   = '0;
    st_we    = 1'b0;
    if (halted) begin
      pc_d = pc;
    end else begin
      case (opcode)
        OpLui: begin
          rd_we  = 1'b1;
          rd_val = imm_u;
        end
        OpAuipc: begin
          rd_we  = 1'b1;
          rd_val = pc + imm_u;
        end
        OpJal: begin
          rd_we  = 1'b1;
          rd_val = pc_plus4;
          pc_d   = pc + imm_j;
        end
        OpJalr: begin
          if (funct3 == 3'b000) begin
            rd_we  = 1'b1;
            rd_val = pc_plus4;
            pc_d   = (rs1_val + imm_i) & ~64'd1;
          end
        end
        OpBranch: begin
          if (br_valid && br_taken) pc_d = pc + imm_b;
        end
        OpLoad: begin
          rd_we  = ld_valid;
          rd_val = ld_val;
        end
        OpStore: begin
          st_we = ~funct3[2];
        end
        OpImm: begin
          rd_we = 1'b1;
          case (funct3)
            3'b000: rd_val = rs1_val + imm_i;
            3'b010: rd_val = ($signed(rs1_val) < $signed(imm_i)) ? 64'd1 : 64'd0;
            3'b011: rd_val = (rs1_val < imm_i) ? 64'd1 : 64'd0;
            3'b100: rd_val = rs1_val ^ imm_i;
            3'b110: rd_val = rs1_val | imm_i;
            3'b111: rd_val = rs1_val & imm_i;
            3'b001: begin
              rd_we  = (instr[31:26] == 6'b000000);
              rd_val = rs1_val << instr[25:20];
            end
            default: begin
              if (instr[31:26] == 6'b000000) begin
                rd_val = rs1_val >> instr[25:20];
              end else if (instr[31:26] == 6'b010000) begin
                rd_val = $signed(rs1_val) >>> instr[25:20];
              end else begin
                rd_we = 1'b0;
              end
            end
          endcase
        end
        OpReg: begin
          rd_we = 1'b1;
          case ({funct7, funct3})
            {7'h00, 3'b000}: rd_val = rs1_val + rs2_val;
            {7'h20, 3'b000}: rd_val = rs1_val - rs2_val;
            {7'h00, 3'b001}: rd_val = rs1_val << rs2_val[5:0];
            {7'h00, 3'b010}: rd_val = ($signed(rs1_val) < $signed(rs2_val)) ? 64'd1 : 64'd0;
            {7'h00, 3'b011}: rd_val = (rs1_val < rs2_val) ? 64'd1 : 64'd0;
            {7'h00, 3'b100}: rd_val = rs1_val ^ rs2_val;
            {7'h00, 3'b101}: rd_val = rs1_val >> rs2_val[5:0];
            {7'h20, 3'b101}: rd_val = $signed(rs1_val) >>> rs2_val[5:0];
            {7'h00, 3'b110}: rd_val = rs1_val | rs2_val;
            {7'h00, 3'b111}: rd_val = rs1_val & rs2_val;
            default:         rd_we  = 1'b0;
          endcase
        end
        OpImm32: begin
          rd_we = 1'b1;
          case ({funct7, funct3})
            {7'h00, 3'b001}: rd_val = sext32(rs1_val[31:0] << instr[24:20]);
            {7'h00, 3'b101}: rd_val = sext32(rs1_val[31:0] >> instr[24:20]);
            {7'h20, 3'b101}: rd_val = sext32($signed(rs1_val[31:0]) >>> instr[24:20]);
            default: begin
              // ADDIW has a full 12-bit immediate in the funct7 field.
              if (funct3 == 3'b000) rd_val = sext32(rs1_val[31:0] + imm_i[31:0]);
              else                  rd_we  = 1'b0;
            end
          endcase
        end
        OpReg32: begin
          rd_we = 1'b1;
          case ({funct7, funct3})
            {7'h00, 3'b000}: rd_val = sext32(rs1_val[31:0] + rs2_val[31:0]);
            {7'h20, 3'b000}: rd_val = sext32(rs1_val[31:0] - rs2_val[31:0]);
            {7'h00, 3'b001}: rd_val = sext32(rs1_val[31:0] << rs2_val[4:0]);
            {7'h00, 3'b101}: rd_val = sext32(rs1_val[31:0] >> rs2_val[4:0]);
            {7'h20, 3'b101}: rd_val = sext32($signed(rs1_val[31:0]) >>> rs2_val[4:0]);
            default:         rd_we  = 1'b0;
          endcase
        end
        OpSystem: begin
          // Only EBREAK does anything; ECALL and CSR ops are NOPs.
          if (instr == InstrEbreak) begin
            halted_d = 1'b1;
            pc_d     = pc;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State commit
  // ---------------------------------------------------------------------------

  // pc, halt flag and register file; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      pc     <= pc_d;
      halted <= halted_d;
      if (rd_we && (rd != 5'd0)) begin
        regs[rd] <= rd_val;
      end
    end
  end

  // Store commit; data memory is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && st_we) begin
      dmem[dmem_idx] <= st_merged;
    end
  end

endmodule

// File: tb/tb_riscv_core.sv
// Directed bench for riscv_core: small programs are written into imem while the
// core is held in reset, then registers, pc and dmem are compared with
// hand-computed values.
module tb_riscv_core;

  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpImm32 = 7'b0011011;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  riscv_core #(
    .RESET_PC   (64'h0),
    .IMEM_WORDS (4096),
    .DMEM_DWORDS(4096),
    .IMEM_INIT  ("")
  ) dut (
    .clk(clk),
    .rst(rst)
  );

  // Rising edges at 10, 20, 30 ...; falling edges at 5, 15, 25 ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                        input logic [6:0] op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OpReg};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [11:0] s;
    s = 12'(imm);
    return {s[11:5], 5'(rs2), 5'(rs1), 3'(f3), s[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3), b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] j;
    j = 21'(imm);
    return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd);
    return {20'(imm20), 5'(rd), OpLui};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    dut.imem[12'(addr >> 2)] = w;
  endtask

  // Unused words default to EBREAK so a runaway program halts.
  task automatic clear_imem();
    for (int i = 0; i < 64; i++) dut.imem[12'(i)] = Ebreak;
  endtask

  function automatic logic [63:0] regs_or();
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.regs[5'(i)];
    return acc;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!dut.halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("halt_reached", {63'd0, dut.halted}, 64'd1);
  endtask

  task automatic load_ctrl_prog();
    clear_imem();
    put(32'h00, enc_i(10, 0, 0, 1, OpImm));     // addi x1,x0,10
    put(32'h04, enc_i(-1, 1, 0, 1, OpImm));     // L: addi x1,x1,-1
    put(32'h08, enc_b(-4, 0, 1, 1));            // bne x1,x0,L
    put(32'h0C, enc_j(20, 0));                  // jal x0,0x20
    put(32'h20, enc_j(8, 5));                   // jal x5,+8
    put(32'h28, enc_i(7, 0, 0, 0, OpImm));      // addi x0,x0,7
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- reset and arithmetic ----------------
    rst = 1'b0;
    clear_imem();
    put(32'h00, enc_i(-1, 0, 0, 1, OpImm));        // addi x1,x0,-1
    put(32'h04, enc_i(5, 0, 0, 2, OpImm));         // addi x2,x0,5
    put(32'h08, enc_r(0, 2, 1, 0, 3));             // add x3,x1,x2
    put(32'h0C, enc_r(32, 1, 2, 0, 4));            // sub x4,x2,x1
    put(32'h10, enc_r(0, 1, 2, 3, 5));             // sltu x5,x2,x1
    put(32'h14, enc_i(32'h404, 1, 5, 6, OpImm));   // srai x6,x1,4
    put(32'h18, enc_i(32'h7ff, 0, 0, 7, OpImm32)); // addiw x7,x0,0x7ff
    put(32'h1C, enc_i(21, 7, 1, 8, OpImm32));      // slliw x8,x7,21
    #1;
    check("rst_pc", dut.pc, 64'h0);
    #43;
    check("rst_pc_held", dut.pc, 64'h0);
    check("rst_halted", {63'd0, dut.halted}, 64'd0);
    check("rst_regs_zero", regs_or(), 64'h0);
    #1;
    rst = 1'b1;
    step(1);
    check("first_pc", dut.pc, 64'h4);
    check("first_x1", dut.regs[1], 64'hFFFF_FFFF_FFFF_FFFF);
    wait_halt(50);
    check("add_x3", dut.regs[3], 64'd4);
    check("sub_x4", dut.regs[4], 64'd6);
    check("sltu_x5", dut.regs[5], 64'd1);
    check("srai_x6", dut.regs[6], 64'hFFFF_FFFF_FFFF_FFFF);
    check("addiw_x7", dut.regs[7], 64'h7FF);
    check("slliw_x8", dut.regs[8], 64'hFFFF_FFFF_FFE0_0000);

    // ---------------- memory ----------------
    @(negedge clk);
    rst = 1'b0;
    clear_imem();
    put(32'h00, enc_u(32'h88776, 1));              // lui x1,0x88776
    put(32'h04, enc_i(32'h655, 1, 0, 1, OpImm));   // addi x1,x1,0x655
    put(32'h08, enc_i(32, 1, 1, 1, OpImm));        // slli x1,x1,32
    put(32'h0C, enc_u(32'h44332, 2));              // lui x2,0x44332
    put(32'h10, enc_i(32'h211, 2, 0, 2, OpImm));   // addi x2,x2,0x211
    put(32'h14, enc_r(0, 2, 1, 6, 1));             // or x1,x1,x2
    put(32'h18, enc_i(32'h100, 0, 0, 3, OpImm));   // addi x3,x0,0x100
    put(32'h1C, enc_s(0, 1, 3, 3));                // sd x1,0(x3)
    put(32'h20, enc_i(32'hAA, 0, 0, 4, OpImm));    // addi x4,x0,0xAA
    put(32'h24, enc_s(3, 4, 3, 0));                // sb x4,3(x3)
    put(32'h28, enc_i(3, 3, 0, 5, OpLoad));        // lb x5,3(x3)
    put(32'h2C, enc_i(0, 3, 5, 6, OpLoad));        // lhu x6,0(x3)
    put(32'h30, enc_i(4, 3, 2, 7, OpLoad));        // lw x7,4(x3)
    put(32'h34, enc_i(0, 3, 3, 8, OpLoad));        // ld x8,0(x3)
    put(32'h38, enc_i(1, 3, 1, 9, OpLoad));        // lh x9,1(x3): addr[0] ignored
    put(32'h3C, enc_i(6, 3, 6, 10, OpLoad));       // lwu x10,6(x3): addr[1:0] ignored
    @(negedge clk);
    rst = 1'b1;
    wait_halt(60);
    check("build_x1", dut.regs[1], 64'h8877_6655_4433_2211);
    check("lb_x5", dut.regs[5], 64'hFFFF_FFFF_FFFF_FFAA);
    check("lhu_x6", dut.regs[6], 64'h2211);
    check("lw_x7", dut.regs[7], 64'hFFFF_FFFF_8877_6655);
    check("ld_x8", dut.regs[8], 64'h8877_6655_AA33_2211);
    check("lh_misaligned_x9", dut.regs[9], 64'h2211);
    check("lwu_misaligned_x10", dut.regs[10], 64'h0000_0000_8877_6655);
    check("dmem_dword", dut.dmem[32], 64'h8877_6655_AA33_2211);

    // ---------------- control flow, x0, halt ----------------
    @(negedge clk);
    rst = 1'b0;
    load_ctrl_prog();
    @(negedge clk);
    rst = 1'b1;
    step(20);
    check("loop_pc_20", dut.pc, 64'h8);
    step(1);
    check("loop_pc_21", dut.pc, 64'hC);
    check("loop_x1", dut.regs[1], 64'h0);
    step(2);
    check("jal_pc", dut.pc, 64'h28);
    check("jal_x5", dut.regs[5], 64'h24);
    step(1);
    check("x0_zero", dut.regs[0], 64'h0);
    step(1);
    check("ebreak_halted", {63'd0, dut.halted}, 64'd1);
    check("ebreak_pc", dut.pc, 64'h2C);
    step(100);
    check("halt_pc_hold", dut.pc, 64'h2C);
    check("halt_flag_hold", {63'd0, dut.halted}, 64'd1);
    check("halt_x5_hold", dut.regs[5], 64'h24);
    check("halt_regs_or", regs_or(), 64'h24);
    check("halt_dmem_hold", dut.dmem[32], 64'h8877_6655_AA33_2211);
    #2;
    rst = 1'b0;
    #1;
    check("rst_clears_halt", {63'd0, dut.halted}, 64'd0);
    check("rst_halt_pc", dut.pc, 64'h0);

    // ---------------- reset mid-run ----------------
    @(negedge clk);
    rst = 1'b1;
    step(7);
    check("midrun_x1", dut.regs[1], 64'd7);
    check("midrun_pc", dut.pc, 64'h4);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_pc", dut.pc, 64'h0);
    check("async_rst_regs", regs_or(), 64'h0);
    step(1);
    check("async_rst_pc_held", dut.pc, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    step(21);
    check("rerun_pc_21", dut.pc, 64'hC);
    check("rerun_x1", dut.regs[1], 64'h0);
    wait_halt(20);
    check("rerun_x5", dut.regs[5], 64'h24);
    check("rerun_pc_halt", dut.pc, 64'h2C);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
